// File: rtl/aes_ks_pkg.sv
// Shared types and GF(2^8) helpers for the AES key schedule.
// inv_mix_col is only referenced when AES_KS_EQINV_EN is defined.
package aes_ks_pkg;

    typedef enum logic [1:0] {
        KL128 = 2'd0,
        KL192 = 2'd1,
        KL256 = 2'd2
    } keylen_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } ks_state_t;

    function automatic logic [3:0] nk_of(keylen_t kl);
        case (kl)
            KL192:   return 4'd6;
            KL256:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(keylen_t kl);
        case (kl)
            KL192:   return 4'd12;
            KL256:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant built from the x, x^2, x^3 multiples.
    function automatic logic [7:0] gmul(logic [7:0] a, logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Start request and round-key stream of the AES key schedule.
// AES_KS_EQINV_EN adds the eq_inv request bit.
interface aes_key_schedule_if #(
    parameter int MAX_NK = 8
);
    logic                  start;
    logic                  start_ready;
    logic [1:0]            key_len;
    logic [32*MAX_NK-1:0]  key;
    logic                  rk_valid;
    logic                  rk_ready;
    logic [127:0]          rk_data;
    logic [3:0]            rk_idx;
    logic                  rk_last;
    logic                  busy;
`ifdef AES_KS_EQINV_EN
    logic                  eq_inv;

    modport master (output start, key_len, key, rk_ready, eq_inv,
                    input  start_ready, rk_valid, rk_data, rk_idx, rk_last, busy);
    modport slave  (input  start, key_len, key, rk_ready, eq_inv,
                    output start_ready, rk_valid, rk_data, rk_idx, rk_last, busy);
`else
    modport master (output start, key_len, key, rk_ready,
                    input  start_ready, rk_valid, rk_data, rk_idx, rk_last, busy);
    modport slave  (input  start, key_len, key, rk_ready,
                    output start_ready, rk_valid, rk_data, rk_idx, rk_last, busy);
`endif
endinterface

// File: rtl/aes_ks_subword.sv
// SubWord: four parallel AES S-box lookups.
module aes_ks_subword (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    // Entry b sits at bits [2047-8b -: 8], i.e. index {~b, 3'b111}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign dout[8*k +: 8] = SBOX[{~din[8*k +: 8], 3'b111} -: 8];
    end
endmodule

// File: rtl/aes_ks_word.sv
// Next expansion word for i >= Nk: RotWord/SubWord/Rcon selection by i%Nk.
module aes_ks_word (
    input  logic [31:0] prev,
    input  logic [31:0] old,
    input  logic [2:0]  phase,
    input  logic        nk8,
    input  logic [7:0]  rcon,
    output logic [31:0] next_w
);
    logic [31:0] sub_in, sub_out;

    assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_ks_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        next_w = old ^ prev;
        if (phase == 3'd0)
            next_w = old ^ sub_out ^ {rcon, 24'h0};
        else if (nk8 && phase == 3'd4)
            next_w = old ^ sub_out;
    end
endmodule

// File: rtl/aes_key_schedule.sv
// Run-time AES-128/192/256 key expander streaming round keys 0..Nr over valid/ready.
// Define AES_KS_EQINV_EN to add eq_inv (InvMixColumns on round keys 1..Nr-1).
//
//  state  | meaning
//  S_IDLE | waiting for start, start_ready=1
//  S_RUN  | one word per cycle while not backpressured; leaves on last handshake
module aes_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input logic                clk,
    input logic                reset_n,
    aes_key_schedule_if.slave  bus
);
    localparam int KW = 32 * MAX_NK;

    ks_state_t        state_q, state_d;
    keylen_t          kl_sel;
    logic [KW-1:0]    key_q;
    logic [7:0][31:0] hist_q;
    logic [95:0]      pbuf_q;
    logic [3:0]       nk_q, nr_q, rk_idx_q;
    logic [5:0]       i_q, words_end;
    logic [2:0]       phase_q, old_idx;
    logic [1:0]       pack_cnt_q;
    logic [7:0]       rcon_q;
    logic [127:0]     rk_data_q, rk_plain, rk_next;
    logic             rk_valid_q, rk_last_q;
    logic             accept, hs, from_key, gen_en, load;
    logic [31:0]      w_calc, w_new;
`ifdef AES_KS_EQINV_EN
    logic             eq_inv_q;
`endif

    // Key lengths wider than the key port fall back to AES-128.
    always_comb begin
        kl_sel = KL128;
        if (bus.key_len == 2'd2 && MAX_NK >= 8)
            kl_sel = KL256;
        else if (bus.key_len == 2'd1 && MAX_NK >= 6)
            kl_sel = KL192;
    end

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign hs        = rk_valid_q && bus.rk_ready;
    assign from_key  = ({2'b00, nk_q} > i_q);
    assign words_end = {nr_q, 2'b00} + 6'd4;
    assign gen_en    = (state_q == S_RUN) && (i_q != words_end) &&
                       !(pack_cnt_q == 2'd3 && rk_valid_q && !bus.rk_ready);
    assign load      = gen_en && (pack_cnt_q == 2'd3);
    assign old_idx   = nk_q[2:0] - 3'd1;
    assign w_new     = from_key ? key_q[KW-1 -: 32] : w_calc;

    aes_ks_word u_word (
        .prev   (hist_q[0]),
        .old    (hist_q[old_idx]),
        .phase  (phase_q),
        .nk8    (nk_q == 4'd8),
        .rcon   (rcon_q),
        .next_w (w_calc)
    );

    always_comb begin
        rk_plain = {pbuf_q, w_new};
        rk_next  = rk_plain;
`ifdef AES_KS_EQINV_EN
        if (eq_inv_q && (i_q[5:2] != 4'd0) && (i_q[5:2] != nr_q))
            rk_next = {inv_mix_col(rk_plain[127:96]), inv_mix_col(rk_plain[95:64]),
                       inv_mix_col(rk_plain[63:32]),  inv_mix_col(rk_plain[31:0])};
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (hs && rk_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= '0;
            hist_q     <= '0;
            pbuf_q     <= '0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            i_q        <= '0;
            phase_q    <= '0;
            pack_cnt_q <= '0;
            rcon_q     <= 8'h01;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
`ifdef AES_KS_EQINV_EN
            eq_inv_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                key_q      <= bus.key;
                nk_q       <= nk_of(kl_sel);
                nr_q       <= nr_of(kl_sel);
                i_q        <= '0;
                phase_q    <= '0;
                pack_cnt_q <= '0;
                rcon_q     <= 8'h01;
`ifdef AES_KS_EQINV_EN
                eq_inv_q   <= bus.eq_inv;
`endif
            end else if (gen_en) begin
                key_q      <= {key_q[KW-33:0], 32'h0};
                hist_q     <= {hist_q[6:0], w_new};
                pbuf_q     <= {pbuf_q[63:0], w_new};
                i_q        <= i_q + 6'd1;
                phase_q    <= ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
                pack_cnt_q <= pack_cnt_q + 2'd1;
                if (!from_key && phase_q == 3'd0)
                    rcon_q <= xtime(rcon_q);
            end
            if (hs)
                rk_valid_q <= 1'b0;
            // A load may coincide with the handshake of the previous key.
            if (load) begin
                rk_valid_q <= 1'b1;
                rk_data_q  <= rk_next;
                rk_idx_q   <= i_q[5:2];
                rk_last_q  <= (i_q[5:2] == nr_q);
            end
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.rk_valid    = rk_valid_q;
    assign bus.rk_data     = rk_data_q;
    assign bus.rk_idx      = rk_idx_q;
    assign bus.rk_last     = rk_last_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 expansion vectors.
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    aes_key_schedule_if #(.MAX_NK(8)) bus ();
    aes_key_schedule #(.MAX_NK(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [127:0] got_data [16];
    logic [3:0]   got_idx  [16];
    logic         got_last [16];
    int           got_cyc  [16];
    int           n_got, stable_err, busy_err;
    logic         sr_after, valid_after;
    bit           timed_out;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] exp128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // Runs one expansion and records every distinct round key as it appears.
    task automatic run_keys(input logic [1:0] kl, input logic [255:0] k,
                            input bit rnd_ready, input bit pester);
        logic         held;
        logic [127:0] hd;
        logic [3:0]   hi;
        logic         hl;
        bit           done;
        n_got = 0; stable_err = 0; busy_err = 0; timed_out = 0;
        done = 0; held = 0; hd = '0; hi = '0; hl = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_len = kl; bus.key = k; bus.rk_ready = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (pester && c >= 2 && c < 12) begin
                bus.start = 1'b1; bus.key_len = 2'd2; bus.key = ~k;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.start_ready !== 1'b0 || bus.busy !== 1'b1) busy_err++;
            bus.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                if (bus.rk_valid !== 1'b1 || bus.rk_data !== hd ||
                    bus.rk_idx !== hi || bus.rk_last !== hl) stable_err++;
            end else if (bus.rk_valid === 1'b1) begin
                if (n_got < 16) begin
                    got_data[n_got] = bus.rk_data;
                    got_idx[n_got]  = bus.rk_idx;
                    got_last[n_got] = bus.rk_last;
                    got_cyc[n_got]  = c;
                end
                n_got++;
                hd = bus.rk_data; hi = bus.rk_idx; hl = bus.rk_last;
            end
            held = bus.rk_valid && !bus.rk_ready;
            if (bus.rk_valid === 1'b1 && bus.rk_ready && bus.rk_last === 1'b1) done = 1;
        end
        bus.start = 1'b0;
        if (!done) timed_out = 1;
        @(negedge clk);
        sr_after = bus.start_ready;
        valid_after = bus.rk_valid;
        bus.rk_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b expected 1", bus.start_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b expected 0", bus.rk_valid); end
        checks++; if (bus.rk_data !== 128'h0) begin errors++; $display("FAIL reset_rk_data: got %h expected 0", bus.rk_data); end
        checks++; if (bus.rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx: got %0d expected 0", bus.rk_idx); end
        checks++; if (bus.rk_last !== 1'b0) begin errors++; $display("FAIL reset_rk_last: got %b expected 0", bus.rk_last); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128;
        run_keys(2'd0, {K128, 128'h0}, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL aes128_timeout: got no last key expected one"); end
        checks++; if (n_got !== 11) begin errors++; $display("FAIL aes128_count: got %0d expected 11", n_got); end
        for (int r = 0; r < 11; r++) begin
            if (r < n_got) begin
                checks++; if (got_data[r] !== exp128[r]) begin errors++; $display("FAIL aes128_rk%0d: got %h expected %h", r, got_data[r], exp128[r]); end
                checks++; if (got_idx[r] !== 4'(r)) begin errors++; $display("FAIL aes128_idx%0d: got %0d expected %0d", r, got_idx[r], r); end
                checks++; if (got_last[r] !== (r == 10)) begin errors++; $display("FAIL aes128_last%0d: got %b expected %b", r, got_last[r], r == 10); end
                checks++; if (got_cyc[r] !== 4 * (r + 1)) begin errors++; $display("FAIL aes128_cycle%0d: got %0d expected %0d", r, got_cyc[r], 4 * (r + 1)); end
            end
        end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL aes128_busy: got %0d bad cycles expected 0", busy_err); end
        checks++; if (sr_after !== 1'b1) begin errors++; $display("FAIL aes128_ready_after: got %b expected 1", sr_after); end
        checks++; if (valid_after !== 1'b0) begin errors++; $display("FAIL aes128_valid_after: got %b expected 0", valid_after); end
    endtask

    task automatic test_aes192;
        run_keys(2'd1, {K192, 64'h0}, 1'b0, 1'b0);
        checks++; if (n_got !== 13) begin errors++; $display("FAIL aes192_count: got %0d expected 13", n_got); end
        checks++; if (got_data[0] !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin errors++; $display("FAIL aes192_rk0: got %h", got_data[0]); end
        checks++; if (got_data[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin errors++; $display("FAIL aes192_rk1: got %h expected 62f8ead2522c6b7bfe0c91f72402f5a5", got_data[1]); end
        checks++; if (got_data[12] !== 128'he98ba06f448c773c8ecc720401002202) begin errors++; $display("FAIL aes192_rk12: got %h expected e98ba06f448c773c8ecc720401002202", got_data[12]); end
        checks++; if (got_idx[12] !== 4'd12 || got_last[12] !== 1'b1) begin errors++; $display("FAIL aes192_last: got idx %0d last %b expected 12 1", got_idx[12], got_last[12]); end
        checks++; if (got_last[11] !== 1'b0) begin errors++; $display("FAIL aes192_last11: got %b expected 0", got_last[11]); end
        checks++; if (got_cyc[12] !== 52) begin errors++; $display("FAIL aes192_cycle: got %0d expected 52", got_cyc[12]); end
    endtask

    task automatic test_aes256;
        run_keys(2'd2, K256, 1'b0, 1'b0);
        checks++; if (n_got !== 15) begin errors++; $display("FAIL aes256_count: got %0d expected 15", n_got); end
        checks++; if (got_data[0] !== 128'h603deb1015ca71be2b73aef0857d7781) begin errors++; $display("FAIL aes256_rk0: got %h", got_data[0]); end
        checks++; if (got_data[1] !== 128'h1f352c073b6108d72d9810a30914dff4) begin errors++; $display("FAIL aes256_rk1: got %h", got_data[1]); end
        checks++; if (got_data[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin errors++; $display("FAIL aes256_rk2: got %h expected 9ba354118e6925afa51a8b5f2067fcde", got_data[2]); end
        checks++; if (got_data[3] !== 128'ha8b09c1a93d194cdbe49846eb75d5b9a) begin errors++; $display("FAIL aes256_rk3: got %h expected a8b09c1a93d194cdbe49846eb75d5b9a", got_data[3]); end
        checks++; if (got_data[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin errors++; $display("FAIL aes256_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", got_data[14]); end
        checks++; if (got_idx[14] !== 4'd14 || got_last[14] !== 1'b1) begin errors++; $display("FAIL aes256_last: got idx %0d last %b expected 14 1", got_idx[14], got_last[14]); end
        checks++; if (got_cyc[14] !== 60) begin errors++; $display("FAIL aes256_cycle: got %0d expected 60", got_cyc[14]); end
    endtask

    task automatic test_stall;
        run_keys(2'd0, {K128, 128'h0}, 1'b1, 1'b0);
        checks++; if (n_got !== 11) begin errors++; $display("FAIL stall_count: got %0d expected 11", n_got); end
        checks++; if (stable_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stable_err); end
        for (int r = 0; r < 11; r++) begin
            if (r < n_got) begin
                checks++; if (got_data[r] !== exp128[r] || got_idx[r] !== 4'(r)) begin errors++; $display("FAIL stall_rk%0d: got %h idx %0d expected %h idx %0d", r, got_data[r], got_idx[r], exp128[r], r); end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen3 = 0;
        bit seen4 = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_len = 2'd0; bus.key = {K128, 128'h0}; bus.rk_ready = 1'b1;
        for (int c = 0; c < 100 && !seen4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rk_valid === 1'b1 && bus.rk_idx === 4'd3) seen3 = 1;
            if (seen3 && bus.rk_valid === 1'b1 && bus.rk_idx === 4'd4) seen4 = 1;
        end
        checks++; if (!seen4) begin errors++; $display("FAIL midreset_reach: got no rk_idx4 expected one"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.rk_valid); end
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL midreset_start_ready: got %b expected 1", bus.start_ready); end
        checks++; if (bus.rk_idx !== 4'd0) begin errors++; $display("FAIL midreset_idx: got %0d expected 0", bus.rk_idx); end
        @(negedge clk);
        reset_n = 1'b1;
        run_keys(2'd0, {K128, 128'h0}, 1'b0, 1'b0);
        checks++; if (n_got !== 11) begin errors++; $display("FAIL midreset_count: got %0d expected 11", n_got); end
        checks++; if (got_data[0] !== exp128[0] || got_idx[0] !== 4'd0) begin errors++; $display("FAIL midreset_rk0: got %h idx %0d", got_data[0], got_idx[0]); end
        checks++; if (got_data[10] !== exp128[10]) begin errors++; $display("FAIL midreset_rk10: got %h expected %h", got_data[10], exp128[10]); end
    endtask

    task automatic test_busy_keylen3;
        run_keys(2'd0, {K128, 128'h0}, 1'b0, 1'b1);
        checks++; if (n_got !== 11) begin errors++; $display("FAIL busystart_count: got %0d expected 11", n_got); end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL busystart_busy: got %0d bad cycles expected 0", busy_err); end
        for (int r = 0; r < 11; r++) begin
            if (r < n_got) begin
                checks++; if (got_data[r] !== exp128[r]) begin errors++; $display("FAIL busystart_rk%0d: got %h expected %h", r, got_data[r], exp128[r]); end
            end
        end
        run_keys(2'd3, {K128, 128'h0}, 1'b0, 1'b0);
        checks++; if (n_got !== 11) begin errors++; $display("FAIL keylen3_count: got %0d expected 11", n_got); end
        checks++; if (got_data[10] !== exp128[10] || got_last[10] !== 1'b1) begin errors++; $display("FAIL keylen3_rk10: got %h last %b expected %h 1", got_data[10], got_last[10], exp128[10]); end
        checks++; if (got_data[1] !== exp128[1]) begin errors++; $display("FAIL keylen3_rk1: got %h expected %h", got_data[1], exp128[1]); end
        checks++; if (sr_after !== 1'b1) begin errors++; $display("FAIL keylen3_ready_after: got %b expected 1", sr_after); end
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.key_len = 2'd0;
        bus.key     = '0;
        bus.rk_ready = 1'b1;
`ifdef AES_KS_EQINV_EN
        bus.eq_inv  = 1'b0;
`endif
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_stall();
        test_reset_mid();
        test_busy_keylen3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
